// File: rtl/video_tile_integrator.sv
`default_nettype none
// ============================================================================
// Module : video_tile_integrator
// Per-tile intensity sum / threshold count over a frame, double-buffered readout.
// Rev    : 1.0
// ============================================================================
module video_tile_integrator #(
   parameter int PIX_W   = 8,
   parameter int COL_W   = 10,
   parameter int ROW_W   = 10,
   parameter int TSH_X   = 7,
   parameter int TSH_Y   = 7,
   parameter int TILES_X = 5,
   parameter int TILES_Y = 4,
   parameter int ACC_W   = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             frame_start,
   input  logic             frame_end,
   input  logic             pix_valid,
   input  logic [COL_W-1:0] pix_col,
   input  logic [ROW_W-1:0] pix_row,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             mode,
   input  logic [PIX_W-1:0] thresh,
   input  logic             rd_req,
   input  logic [7:0]       rd_idx,
   output logic             rd_valid,
   output logic [ACC_W-1:0] rd_data,
   output logic             frame_done,
   output logic [15:0]      frame_count,
   output logic             busy,
   output logic             sat_flag
);

   localparam int          c_NT     = TILES_X * TILES_Y;
   localparam int          c_IDX_W  = (c_NT > 1) ? $clog2(c_NT) : 1;
   localparam int          c_TX_W   = COL_W - TSH_X;
   localparam int          c_TY_W   = ROW_W - TSH_Y;
   localparam int          c_SUM_W  = ACC_W + 1;
   localparam logic [31:0] c_TX_LIM = 32'(TILES_X);
   localparam logic [31:0] c_TY_LIM = 32'(TILES_Y);
   localparam logic [31:0] c_NT_LIM = 32'(c_NT);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_ACCUM  = 3'd1;
   localparam logic [2:0] c_DRAIN1 = 3'd2;
   localparam logic [2:0] c_DRAIN2 = 3'd3;
   localparam logic [2:0] c_COMMIT = 3'd4;

   logic [2:0]         state_q, state_d;
   logic               w_clear, w_open, w_commit;

   logic               mode_q;
   logic [PIX_W-1:0]   thr_q;
   logic               s1_valid_q;
   logic [c_IDX_W-1:0] s1_idx_q;
   logic [PIX_W-1:0]   s1_contrib_q;
   logic [ACC_W-1:0]   acc_q [c_NT];
   logic [ACC_W-1:0]   res_q [c_NT];
   logic               sat_q;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= c_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_IDLE:   if (frame_start) state_d = c_ACCUM;
         c_ACCUM:  if (!frame_start && frame_end) state_d = c_DRAIN1;
         c_DRAIN1: state_d = c_DRAIN2;
         c_DRAIN2: state_d = c_COMMIT;
         c_COMMIT: state_d = c_IDLE;
         default:  state_d = c_IDLE;
      endcase
   end

   // w_clear restarts accumulation; w_open admits the current cycle's pixel
   always_comb begin
      busy       = 1'b0;
      frame_done = 1'b0;
      w_clear    = 1'b0;
      w_open     = 1'b0;
      w_commit   = 1'b0;
      case (state_q)
         c_IDLE: begin
            w_clear = frame_start;
            w_open  = frame_start;
         end
         c_ACCUM: begin
            busy    = 1'b1;
            w_clear = frame_start;
            w_open  = 1'b1;
         end
         c_DRAIN1, c_DRAIN2: busy = 1'b1;
         c_COMMIT: begin
            frame_done = 1'b1;
            w_commit   = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------- Stage 1: tile lookup and contribution ----------------
   logic [c_TX_W-1:0]  w_tx;
   logic [c_TY_W-1:0]  w_ty;
   logic               w_in_range;
   logic [c_IDX_W-1:0] w_idx;
   logic               w_mode;
   logic [PIX_W-1:0]   w_thr;
   logic [PIX_W-1:0]   w_contrib;

   assign w_tx       = pix_col[COL_W-1:TSH_X];
   assign w_ty       = pix_row[ROW_W-1:TSH_Y];
   assign w_in_range = (32'(w_tx) < c_TX_LIM) && (32'(w_ty) < c_TY_LIM);
   assign w_idx      = c_IDX_W'(32'(w_ty) * c_TX_LIM + 32'(w_tx));
   // the frame_start pixel already uses the newly sampled mode/threshold
   assign w_mode     = w_clear ? mode   : mode_q;
   assign w_thr      = w_clear ? thresh : thr_q;
   assign w_contrib  = w_mode ? PIX_W'(pix_data >= w_thr) : pix_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q       <= 1'b0;
         thr_q        <= '0;
         s1_valid_q   <= 1'b0;
         s1_idx_q     <= '0;
         s1_contrib_q <= '0;
      end else begin
         s1_valid_q   <= pix_valid && w_open && w_in_range;
         s1_idx_q     <= w_idx;
         s1_contrib_q <= w_contrib;
         if (w_clear) begin
            mode_q <= mode;
            thr_q  <= thresh;
         end
      end
   end

   // ---------------- Stage 2: saturating accumulate ----------------
   logic [ACC_W-1:0]   w_cur;
   logic [c_SUM_W-1:0] w_sum;
   logic               w_ovf;
   logic [ACC_W-1:0]   w_new;

   assign w_cur = acc_q[s1_idx_q];
   assign w_sum = {1'b0, w_cur} + c_SUM_W'(s1_contrib_q);
   assign w_ovf = w_sum[ACC_W];
   assign w_new = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

   // a clear also discards whatever pre-restart pixel sits in stage 1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < c_NT; i++) acc_q[i] <= '0;
         sat_q <= 1'b0;
      end else if (w_clear) begin
         for (int i = 0; i < c_NT; i++) acc_q[i] <= '0;
         sat_q <= 1'b0;
      end else if (s1_valid_q) begin
         acc_q[s1_idx_q] <= w_new;
         if (w_ovf) sat_q <= 1'b1;
      end
   end

   // ---------------- Result bank and readout ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < c_NT; i++) res_q[i] <= '0;
         frame_count <= '0;
         sat_flag    <= 1'b0;
      end else if (w_commit) begin
         for (int i = 0; i < c_NT; i++) res_q[i] <= acc_q[i];
         frame_count <= frame_count + 16'd1;
         sat_flag    <= sat_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) begin
            rd_data <= ({24'd0, rd_idx} < c_NT_LIM) ? res_q[c_IDX_W'(rd_idx)] : '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_video_tile_integrator.sv
`default_nettype none
// ============================================================================
// Module : tb_video_tile_integrator
// Random + directed frames against a tile-sum reference model (ACC_W 32 and 16).
// Rev    : 1.0
// ============================================================================
module tb_video_tile_integrator;

   localparam int NT = 20;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        frame_start = 1'b0, frame_end = 1'b0, pix_valid = 1'b0;
   logic [9:0]  pix_col = '0, pix_row = '0;
   logic [7:0]  pix_data = '0, thresh = '0, rd_idx = '0;
   logic        mode = 1'b0, rd_req = 1'b0;

   logic        rd_valid, frame_done, busy, sat_flag;
   logic [31:0] rd_data;
   logic [15:0] frame_count;
   logic        rd_valid16, frame_done16, busy16, sat_flag16;
   logic [15:0] rd_data16, frame_count16;

   always #5 clk = ~clk;

   video_tile_integrator dut (
      .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .frame_end(frame_end),
      .pix_valid(pix_valid), .pix_col(pix_col), .pix_row(pix_row), .pix_data(pix_data),
      .mode(mode), .thresh(thresh), .rd_req(rd_req), .rd_idx(rd_idx),
      .rd_valid(rd_valid), .rd_data(rd_data), .frame_done(frame_done),
      .frame_count(frame_count), .busy(busy), .sat_flag(sat_flag));

   video_tile_integrator #(.ACC_W(16)) dut16 (
      .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .frame_end(frame_end),
      .pix_valid(pix_valid), .pix_col(pix_col), .pix_row(pix_row), .pix_data(pix_data),
      .mode(mode), .thresh(thresh), .rd_req(rd_req), .rd_idx(rd_idx),
      .rd_valid(rd_valid16), .rd_data(rd_data16), .frame_done(frame_done16),
      .frame_count(frame_count16), .busy(busy16), .sat_flag(sat_flag16));

   int     checks = 0, errors = 0;
   longint m_acc32[NT], m_acc16[NT], m_res32[NT], m_res16[NT];
   bit     m_sat32, m_sat16, m_satf32, m_satf16, m_mode, m_in_frame;
   int     m_thr, m_fc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: a frame is a 640x512 area cut into 128x128 tiles, 5 per row
   task automatic model_pix(input bit v, input int col, input int row, input int data);
      int     idx;
      longint c;
      if (v && m_in_frame && col < 640 && row < 512) begin
         idx = (row / 128) * 5 + (col / 128);
         c   = m_mode ? ((data >= m_thr) ? 1 : 0) : data;
         if (m_acc32[idx] + c > 64'd4294967295) begin
            m_acc32[idx] = 64'd4294967295; m_sat32 = 1'b1;
         end else m_acc32[idx] += c;
         if (m_acc16[idx] + c > 64'd65535) begin
            m_acc16[idx] = 64'd65535; m_sat16 = 1'b1;
         end else m_acc16[idx] += c;
      end
   endtask

   task automatic set_pix(input bit v, input int col, input int row, input int data);
      pix_valid = v;
      pix_col   = 10'(col);
      pix_row   = 10'(row);
      pix_data  = 8'(data);
      model_pix(v, col, row, data);
   endtask

   task automatic rand_pix();
      set_pix($urandom_range(0, 9) < 8, $urandom_range(0, 767),
              $urandom_range(0, 599), $urandom_range(0, 255));
   endtask

   task automatic pixels(input int n);
      for (int i = 0; i < n; i++) begin
         mode   = 1'($urandom_range(0, 1));
         thresh = 8'($urandom_range(0, 255));
         rand_pix();
         tick();
      end
      pix_valid = 1'b0;
   endtask

   task automatic frame_begin(input bit md, input int th, input bit with_pix);
      mode = md; thresh = 8'(th); frame_start = 1'b1;
      for (int i = 0; i < NT; i++) begin m_acc32[i] = 0; m_acc16[i] = 0; end
      m_sat32 = 0; m_sat16 = 0; m_mode = md; m_thr = th; m_in_frame = 1;
      if (with_pix) rand_pix(); else pix_valid = 1'b0;
      tick();
      frame_start = 1'b0;
      pix_valid   = 1'b0;
      check("busy_accum", busy, 1);
   endtask

   task automatic frame_finish();
      int     n;
      longint old32, old16;
      frame_end = 1'b1;
      rand_pix();
      tick();
      frame_end = 1'b0; m_in_frame = 0; n = 1;
      check("busy_drain", busy, 1);
      while (!frame_done && n < 8) begin
         frame_start = 1'b1;            // must be ignored while draining
         rand_pix();
         tick();
         n++;
      end
      check("frame_done_latency", n, 3);
      frame_start = 1'b1; rand_pix(); rd_req = 1'b1; rd_idx = 8'd3;
      old32 = m_res32[3]; old16 = m_res16[3];
      for (int i = 0; i < NT; i++) begin m_res32[i] = m_acc32[i]; m_res16[i] = m_acc16[i]; end
      m_satf32 = m_sat32; m_satf16 = m_sat16; m_fc = (m_fc + 1) & 16'hFFFF;
      tick();
      frame_start = 1'b0; pix_valid = 1'b0;
      check("commit_read_old32", rd_data, old32);
      check("commit_read_old16", rd_data16, old16);
      check("frame_done_pulse", frame_done, 0);
      check("frame_count", frame_count, m_fc);
      check("frame_count16", frame_count16, m_fc);
      check("sat_flag32", sat_flag, m_satf32);
      check("sat_flag16", sat_flag16, m_satf16);
      tick();
      check("after_commit_read32", rd_data, m_res32[3]);
      check("after_commit_read16", rd_data16, m_res16[3]);
      check("busy_idle", busy, 0);
      rd_req = 1'b0;
   endtask

   task automatic check_all();
      int idx;
      rd_req = 1'b1;
      for (int i = 0; i < NT + 3; i++) begin
         idx    = (i < NT) ? i : (i == NT) ? 20 : (i == NT + 1) ? 200 : 255;
         rd_idx = 8'(idx);
         tick();
         check($sformatf("rd_valid[%0d]", idx), rd_valid, 1);
         check($sformatf("rd32[%0d]", idx), rd_data, (idx < NT) ? m_res32[idx] : 0);
         check($sformatf("rd16[%0d]", idx), rd_data16, (idx < NT) ? m_res16[idx] : 0);
      end
      rd_req = 1'b0;
      tick();
      check("rd_valid_idle", rd_valid, 0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NT; i++) begin
         m_acc32[i] = 0; m_acc16[i] = 0; m_res32[i] = 0; m_res16[i] = 0;
      end
      m_sat32 = 0; m_sat16 = 0; m_satf32 = 0; m_satf16 = 0;
      m_fc = 0; m_in_frame = 0; m_mode = 0; m_thr = 0;
   endtask

   initial begin
      model_reset();
      // power-on reset
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_sat_flag", sat_flag, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      #3 reset_n = 1'b1;
      tick();
      check_all();

      // random sum frame, then random threshold-count frame
      frame_begin(0, 0, 1);
      pixels(2500);
      frame_finish();
      check_all();
      frame_begin(1, 8'h80, 1);
      pixels(2500);
      frame_finish();
      check_all();

      // restart mid-frame: only post-restart pixels survive, one commit
      frame_begin(0, 0, 1);
      pixels(600);
      frame_begin(1, $urandom_range(1, 254), 1);
      pixels(800);
      frame_finish();
      check_all();

      // tile edges and out-of-range coordinates
      frame_begin(0, 0, 0);
      set_pix(1, 639, 511, 11);  tick();
      set_pix(1, 640, 0, 200);   tick();
      set_pix(1, 0, 512, 200);   tick();
      set_pix(1, 1023, 1023, 9); tick();
      set_pix(1, 127, 127, 5);   tick();
      set_pix(1, 128, 128, 7);   tick();
      set_pix(1, 0, 128, 3);     tick();
      pix_valid = 1'b0;
      frame_finish();
      check_all();

      // 16-bit saturation: 258 x 0xFF overflows, 257 x 0xFF lands on 0xFFFF exactly
      for (int f = 0; f < 2; f++) begin
         frame_begin(0, 0, 0);
         for (int i = 0; i < 258 - f; i++) begin
            set_pix(1, $urandom_range(0, 127), $urandom_range(0, 127), 255);
            tick();
         end
         pix_valid = 1'b0;
         frame_finish();
         check_all();
      end

      // asynchronous reset in the middle of an active frame
      frame_begin(0, 0, 1);
      pixels(40);
      frame_begin(1, 8'h40, 1);
      for (int i = 0; i < 30; i++) begin rand_pix(); tick(); end
      #3 reset_n = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_busy16", busy16, 0);
      check("arst_frame_count", frame_count, 0);
      check("arst_sat_flag", sat_flag16, 0);
      check("arst_rd_valid", rd_valid, 0);
      check("arst_frame_done", frame_done, 0);
      model_reset();
      @(posedge clk);
      #4 reset_n = 1'b1;
      rand_pix();
      tick();
      pix_valid = 1'b0;
      check("post_rst_busy", busy, 0);
      check_all();

      // normal operation after reset
      frame_begin(1, $urandom_range(0, 255), 1);
      pixels(300);
      frame_finish();
      check_all();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
